// File: rtl/complex_alu_seq.sv
// Complex add/sub/mul sequencer driving one shared scalar alu.
// The alu is registered with 1-cycle latency, so each result is captured two
// edges after its issue cycle begins. Multiply partial products are combined
// in the DONE state.
module complex_alu_seq #(
  parameter int W  = 5,
  parameter int OW = 2 * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cop,
  input  logic [W-1:0]  a_re,
  input  logic [W-1:0]  a_im,
  input  logic [W-1:0]  b_re,
  input  logic [W-1:0]  b_im,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [OW-1:0] res_re,
  output logic [OW-1:0] res_im,
  output logic [W-1:0]  alu_op1,
  output logic [W-1:0]  alu_op2,
  output logic [1:0]    alu_opcode,
  input  logic [OW-1:0] alu_out,
  input  logic          alu_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] COP_NOP = 2'b00;
  localparam logic [1:0] COP_MUL = 2'b11;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           cop_q, cop_d;
  logic [W-1:0]         a_re_q, a_re_d, a_im_q, a_im_d;
  logic [W-1:0]         b_re_q, b_re_d, b_im_q, b_im_d;
  // iss_q/iss_idx_q mark what the alu sampled at the previous edge, so the
  // matching result is on alu_out during the current cycle.
  logic                 iss_q, iss_d;
  logic [1:0]           iss_idx_q, iss_idx_d;
  logic [3:0][OW-1:0]   p_q, p_d;
  logic                 err_acc_q, err_acc_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [OW-1:0]        res_re_q, res_re_d, res_im_q, res_im_d;
  logic [1:0]           last_idx;

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign res_re = res_re_q;
  assign res_im = res_im_q;

  // Mul needs four scalar issues, add/sub two.
  assign last_idx = (cop_q == COP_MUL) ? 2'd3 : 2'd1;

  // Next-state, alu drive, result capture and final combination.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cop_d      = cop_q;
    a_re_d     = a_re_q;
    a_im_d     = a_im_q;
    b_re_d     = b_re_q;
    b_im_d     = b_im_q;
    iss_d      = (state_q == S_ISSUE);
    iss_idx_d  = idx_q;
    p_d        = p_q;
    err_acc_d  = err_acc_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_re_d   = res_re_q;
    res_im_d   = res_im_q;
    alu_op1    = '0;
    alu_op2    = '0;
    alu_opcode = COP_NOP;

    if (iss_q) begin
      p_d[iss_idx_q] = alu_out;
      err_acc_d      = err_acc_q | ~alu_valid;
    end

    case (state_q)
      S_IDLE: begin
        if (start && cop != COP_NOP) begin
          cop_d     = cop;
          a_re_d    = a_re;
          a_im_d    = a_im;
          b_re_d    = b_re;
          b_im_d    = b_im;
          idx_d     = 2'd0;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          err_acc_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The opcode equals the complex op code; mul uses cross terms at idx 2/3.
        alu_opcode = cop_q;
        case (idx_q)
          2'd0:    begin alu_op1 = a_re_q; alu_op2 = b_re_q; end
          2'd1:    begin alu_op1 = a_im_q; alu_op2 = b_im_q; end
          2'd2:    begin alu_op1 = a_re_q; alu_op2 = b_im_q; end
          default: begin alu_op1 = a_im_q; alu_op2 = b_re_q; end
        endcase
        if (idx_q == last_idx) begin
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        if (cop_q == COP_MUL) begin
          res_re_d = p_q[0] - p_q[1];
          res_im_d = p_q[2] + p_q[3];
        end else begin
          res_re_d = p_q[0];
          res_im_d = p_q[1];
        end
        err_d   = err_acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cop_q     <= '0;
      a_re_q    <= '0;
      a_im_q    <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
      iss_q     <= 1'b0;
      iss_idx_q <= '0;
      p_q       <= '0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_re_q  <= '0;
      res_im_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cop_q     <= cop_d;
      a_re_q    <= a_re_d;
      a_im_q    <= a_im_d;
      b_re_q    <= b_re_d;
      b_im_q    <= b_im_d;
      iss_q     <= iss_d;
      iss_idx_q <= iss_idx_d;
      p_q       <= p_d;
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      res_re_q  <= res_re_d;
      res_im_q  <= res_im_d;
    end
  end

endmodule
